exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the pipelined ARM-subset core. Consumes the control word produced by the ID-stage control unit (EXE_CMD, WB/MEM enables, S, B), runs the ALU, and owns the NZCV status register. It also resolves branches and registers results into the EXE/MEM pipeline register. Sits between the ID/EXE register and the MEM stage.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (Rn, Val2, result, PC).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hold the EXE/MEM register and the status register.
- `flush` in 1: kill the instruction at the inputs.
- `valid_in` in 1: inputs carry a real instruction.
- `exe_cmd` in 4: ALU command from the control unit.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `s_in`, `b_in` in 1 each: control word from the control unit.
- `val_rn` in WIDTH: first operand.
- `val2` in WIDTH: shifted or immediate second operand.
- `val_rm` in WIDTH: store data.
- `dest_in` in 4: destination register.
- `pc_in` in WIDTH: PC of the next instruction.
- `imm24` in 24: branch offset.
- `alu_res` out WIDTH: registered result.
- `val_rm_out` out WIDTH: registered store data.
- `dest_out` out 4: registered destination.
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `valid_out` out 1 each: registered control outputs.
- `status` out 4: NZCV, with N at bit 3.
- `br_taken` out 1: combinational branch resolution.
- `br_addr` out WIDTH: combinational branch target.

## Operation
- ALU, combinational (C is the current status C):
  - 0001: MOV, result = val2.
  - 1001: MVN, result = ~val2.
  - 0010: ADD, result = rn+val2.
  - 0011: ADC, result = rn+val2+C.
  - 0100: SUB, result = rn−val2.
  - 0101: SBC, result = rn−val2−!C.
  - 0110: AND.
  - 0111: ORR.
  - 1000: EOR.
  - Any other code: result 0, no status update.
- Flags for arithmetic commands:
  - N = result[31].
  - Z = (result == 0).
  - C = carry-out of the WIDTH+1-bit sum. Subtraction is computed as rn + ~val2 + 1 (or + C for SBC), so C = 1 means no borrow.
  - V = signed overflow.
- Flags for logical and move commands: N and Z update; C and V are held.
- CMP and TST reach this block as SUB and AND with `wb_en_in` = 0. Loads and stores arrive as ADD.
- Status register writes on the clock edge when valid_in & s_in & !freeze & !flush and exe_cmd is a listed code.
- Branch:
  - br_addr = pc_in + (sign-extended imm24 << 2), modulo 2^WIDTH.
  - br_taken = valid_in & b_in & !flush & !freeze.
- EXE/MEM register update on each clock edge:
  - rst: all registered outputs and status go to 0.
  - Else if freeze: hold everything. Freeze dominates flush.
  - Else if flush, or !valid_in: load a bubble. The enable outputs and valid_out go to 0; data fields keep their previous value.
  - Else: capture the ALU result, val_rm, dest, the three enables, and valid_out = 1.
- A branch (b_in) is captured with all enables 0 and valid_out = 1.

## Timing
- Result latency is 1 cycle, from inputs to `alu_res`.
- `br_taken` and `br_addr` are same-cycle (combinational).
- Status is visible on `status` 1 cycle after the flag-setting instruction.
- An instruction that reads C (ADC, SBC) uses the registered C. A back-to-back ADDS→ADC therefore uses the ADDS carry only when the instruction arrives one cycle after ADDS, which the in-order pipeline guarantees.
- Reset mid-operation: the in-flight instruction is dropped and nothing is written.

## Configuration
- `EXE_STATUS_BYPASS_EN`
  - Defined: `status` shows the next-state value. It equals the flags being written this cycle when a write is enabled, else the register. This lets the ID-stage condition check act one cycle earlier.
  - Undefined: `status` is the register output only.
- Internal ADC/SBC always use the registered C in both modes.

## Test plan
- Reset: assert rst for 2 cycles with arbitrary inputs → all outputs 0 and status 4'b0000.
- ADDS: rn = 32'h7FFFFFFF, val2 = 1, s_in = 1 → next cycle alu_res = 32'h80000000 and status = 4'b1001 (N, V).
- SUBS then ADC:
  - Cycle 1: SUBS with rn = 5, val2 = 5 → status = 4'b0110 (Z, C).
  - Cycle 2: ADC with rn = 1, val2 = 1 → alu_res = 3.
- Freeze and flush: freeze = 1 for 3 cycles with a valid ADD → outputs and status unchanged. Then flush = 1 with a valid ADDS → valid_out = 0, wb_en_out = 0, status unchanged.
- Branch: pc_in = 32'h100, imm24 = 24'hFFFFFE, b_in = 1 → same-cycle br_taken = 1 and br_addr = 32'hF8. Repeat with flush = 1 → br_taken = 0.
- Bypass: with `EXE_STATUS_BYPASS_EN` defined, ANDS producing 0 → status shows Z in the same cycle. Undefined → Z appears one cycle later.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: ARM-subset execute stage (ALU, NZCV register, branch target, EXE/MEM register).
// Define EXE_STATUS_BYPASS_EN to drive status with the next-state flags.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [3:0]       exe_cmd,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             s_in,
    input  logic             b_in,
    input  logic [WIDTH-1:0] val_rn,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [23:0]      imm24,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] val_rm_out,
    output logic [3:0]       dest_out,
    output logic             wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out,
    output logic             valid_out,
    output logic [3:0]       status,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_addr
);
    logic [3:0]       st_q, flags;
    logic             arith, logical, sub, cin, v, st_we;
    logic [WIDTH-1:0] b_op, res;
    logic [WIDTH:0]   sum;

    assign arith   = exe_cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
    assign logical = exe_cmd inside {4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000};
    assign sub     = exe_cmd[3:1] == 3'b010;
    // Subtraction is rn + ~val2 + 1 (SUB) or + C (SBC), so C doubles as not-borrow
    assign cin     = exe_cmd == 4'b0010 ? 1'b0 : exe_cmd == 4'b0100 ? 1'b1 : st_q[1];
    assign b_op    = sub ? ~val2 : val2;
    assign sum     = {1'b0, val_rn} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign v       = (val_rn[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != val_rn[WIDTH-1]);

    assign res = exe_cmd == 4'b0001 ? val2 :
                 exe_cmd == 4'b1001 ? ~val2 :
                 arith              ? sum[WIDTH-1:0] :
                 exe_cmd == 4'b0110 ? val_rn & val2 :
                 exe_cmd == 4'b0111 ? val_rn | val2 :
                 exe_cmd == 4'b1000 ? val_rn ^ val2 : '0;

    assign flags = {res[WIDTH-1], res == '0, arith ? sum[WIDTH] : st_q[1], arith ? v : st_q[0]};
    assign st_we = !rst & valid_in & s_in & !freeze & !flush & (arith | logical);

`ifdef EXE_STATUS_BYPASS_EN
    assign status = st_we ? flags : st_q;
`else
    assign status = st_q;
`endif

    assign br_taken = valid_in & b_in & !flush & !freeze;
    assign br_addr  = pc_in + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= '0;
            alu_res      <= '0;
            val_rm_out   <= '0;
            dest_out     <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            valid_out    <= 1'b0;
        end else if (!freeze) begin
            if (st_we)
                st_q <= flags;
            if (flush || !valid_in) begin
                wb_en_out    <= 1'b0;
                mem_r_en_out <= 1'b0;
                mem_w_en_out <= 1'b0;
                valid_out    <= 1'b0;
            end else begin
                alu_res      <= res;
                val_rm_out   <= val_rm;
                dest_out     <= dest_in;
                wb_en_out    <= wb_en_in & !b_in;
                mem_r_en_out <= mem_r_en_in & !b_in;
                mem_w_en_out <= mem_w_en_in & !b_in;
                valid_out    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: table-driven vectors with a scoreboard model of exe_stage plus directed corner sequences.
module tb_exe_stage;
    logic        clk = 0, rst = 1, freeze = 0, flush = 0, valid_in = 0;
    logic [3:0]  exe_cmd = 0, dest_in = 0;
    logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, s_in = 0, b_in = 0;
    logic [31:0] val_rn = 0, val2 = 0, val_rm = 0, pc_in = 0;
    logic [23:0] imm24 = 0;
    logic [31:0] alu_res, val_rm_out, br_addr;
    logic [3:0]  dest_out, status;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, valid_out, br_taken;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .exe_cmd(exe_cmd), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .s_in(s_in), .b_in(b_in), .val_rn(val_rn),
        .val2(val2), .val_rm(val_rm), .dest_in(dest_in), .pc_in(pc_in), .imm24(imm24),
        .alu_res(alu_res), .val_rm_out(val_rm_out), .dest_out(dest_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .valid_out(valid_out), .status(status), .br_taken(br_taken), .br_addr(br_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cmd;
        logic        s, b, wb, mr, mw, valid, fl, fz;
        logic [31:0] rn, v2, rm;
        logic [3:0]  dest;
    } vec_t;

    typedef struct packed {
        logic [31:0] res, rm;
        logic [3:0]  dest;
        logic        wb, mr, mw, val;
        logic [3:0]  st;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    vec_t        tv[16];
    int          n_vec = 0, errs = 0;

    // Reference ALU built on 64-bit arithmetic: returns {listed, nzcv, result}
    function automatic logic [36:0] alu_m(input logic [3:0] cmd, input logic [31:0] a, b, input logic [3:0] st);
        longint      sa, sb, s;
        longint unsigned ua, ub, u;
        logic [31:0] r;
        logic        c, vf, ar, ls;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'd0, a}; ub = {32'd0, b};
        c = st[1]; vf = st[0]; ar = 1; ls = 1; s = 0; u = 0; r = 0;
        case (cmd)
            4'b0010: begin u = ua + ub;        s = sa + sb; end
            4'b0011: begin u = ua + ub + st[1]; s = sa + sb + st[1]; end
            4'b0100: begin u = 0; s = sa - sb; end
            4'b0101: begin u = 0; s = sa - sb - !st[1]; end
            default: ar = 0;
        endcase
        if (cmd == 4'b0010 || cmd == 4'b0011) begin
            r = u[31:0]; c = u[32];
        end else if (cmd == 4'b0100) begin
            r = a - b; c = ua >= ub;
        end else if (cmd == 4'b0101) begin
            r = a - b - {31'd0, !st[1]}; c = ua >= ub + {63'd0, !st[1]};
        end
        if (ar) vf = s != longint'($signed(r));
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: if (!ar) begin r = 0; ls = 0; end
        endcase
        return {ls, r[31], r == 0, c, vf, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        exe_cmd = t.cmd; s_in = t.s; b_in = t.b; wb_en_in = t.wb; mem_r_en_in = t.mr;
        mem_w_en_in = t.mw; valid_in = t.valid; flush = t.fl; freeze = t.fz;
        val_rn = t.rn; val2 = t.v2; val_rm = t.rm; dest_in = t.dest;
    endtask

    // Update the model from the inputs present at the edge, then compare after it with status writes idle
    task automatic step();
        logic [36:0] a;
        exp_t e;
        a = alu_m(exe_cmd, val_rn, val2, m.st);
        if (rst) m = '0;
        else if (!freeze) begin
            if (valid_in && s_in && !flush && a[36]) m.st = a[35:32];
            if (flush || !valid_in) begin
                m.wb = 0; m.mr = 0; m.mw = 0; m.val = 0;
            end else begin
                m.res = a[31:0]; m.rm = val_rm; m.dest = dest_in;
                m.wb = wb_en_in & !b_in; m.mr = mem_r_en_in & !b_in; m.mw = mem_w_en_in & !b_in;
                m.val = 1;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1 s_in = 0;
        #1;
        e = q.pop_front();
        chk("alu_res", alu_res, e.res);
        chk("val_rm_out", val_rm_out, e.rm);
        chk("dest_out", {28'd0, dest_out}, {28'd0, e.dest});
        chk("enables", {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, valid_out}, {28'd0, e.wb, e.mr, e.mw, e.val});
        chk("status", {28'd0, status}, {28'd0, e.st});
    endtask

    initial begin
        m = '0;
        tv[0]  = '{4'b0001, 1, 0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h11, 4'd1};
        tv[1]  = '{4'b1001, 1, 0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h22, 4'd2};
        tv[2]  = '{4'b0010, 1, 0, 1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h33, 4'd3};
        tv[3]  = '{4'b0011, 1, 0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h44, 4'd4};
        tv[4]  = '{4'b0100, 1, 0, 1, 0, 0, 1, 0, 0, 32'h3, 32'h5, 32'h55, 4'd5};
        tv[5]  = '{4'b0101, 1, 0, 1, 0, 0, 1, 0, 0, 32'h10, 32'h3, 32'h66, 4'd6};
        tv[6]  = '{4'b0111, 1, 0, 1, 0, 0, 1, 0, 0, 32'hF0F00000, 32'h0000F0F0, 32'h77, 4'd7};
        tv[7]  = '{4'b1000, 1, 0, 1, 0, 0, 1, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h88, 4'd8};
        tv[8]  = '{4'b0100, 1, 0, 0, 0, 0, 1, 0, 0, 32'h80000000, 32'h1, 32'h99, 4'd9};
        tv[9]  = '{4'b0010, 0, 0, 1, 1, 0, 1, 0, 0, 32'h1000, 32'h4, 32'hAA, 4'd10};
        tv[10] = '{4'b0010, 0, 0, 0, 0, 1, 1, 0, 0, 32'h2000, 32'h8, 32'hBB, 4'd11};
        tv[11] = '{4'b1111, 1, 0, 1, 0, 0, 1, 0, 0, 32'h1, 32'h1, 32'hCC, 4'd12};
        tv[12] = '{4'b0010, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hDD, 4'd13};
        tv[13] = '{4'b0001, 1, 0, 1, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'hEE, 4'd14};
        tv[14] = '{4'b1001, 1, 0, 1, 0, 0, 1, 0, 1, 32'h0, 32'h5, 32'hFF, 4'd15};
        tv[15] = '{4'b0110, 1, 0, 0, 0, 0, 1, 0, 0, 32'h80000001, 32'h80000000, 32'h12, 4'd1};

        drive('{4'b0010, 1, 0, 1, 1, 1, 1, 0, 0, $urandom, $urandom, $urandom, 4'd9});
        step(); step();
        chk("reset alu_res", alu_res, 32'h0);
        chk("reset status", {28'd0, status}, 32'h0);
        chk("reset valid_out", {31'd0, valid_out}, 32'h0);
        rst = 0;

        drive('{4'b0010, 1, 0, 1, 0, 0, 1, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 4'd3});
        step();
        chk("adds result", alu_res, 32'h80000000);
        chk("adds status", {28'd0, status}, 32'h9);
        drive('{4'b0100, 1, 0, 0, 0, 0, 1, 0, 0, 32'h5, 32'h5, 32'h0, 4'd0});
        step();
        chk("subs status", {28'd0, status}, 32'h6);
        drive('{4'b0011, 0, 0, 1, 0, 0, 1, 0, 0, 32'h1, 32'h1, 32'h0, 4'd2});
        step();
        chk("adc carry in", alu_res, 32'h3);

        drive('{4'b0010, 1, 0, 1, 0, 0, 1, 0, 1, 32'h10, 32'h20, 32'h0, 4'd4});
        for (int i = 0; i < 3; i++) begin
            s_in = 1;
            step();
            chk("freeze alu_res", alu_res, 32'h3);
            chk("freeze status", {28'd0, status}, 32'h6);
        end
        drive('{4'b0010, 1, 0, 1, 0, 0, 1, 1, 0, 32'h1, 32'h1, 32'h0, 4'd4});
        step();
        chk("flush valid/wb", {30'd0, valid_out, wb_en_out}, 32'h0);
        chk("flush status", {28'd0, status}, 32'h6);

        drive('{4'b0000, 0, 1, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0});
        pc_in = 32'h100; imm24 = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'd0, br_taken}, 32'h1);
        chk("br_addr", br_addr, 32'hF8);
        flush = 1; #1;
        chk("br_taken flushed", {31'd0, br_taken}, 32'h0);
        flush = 0;
        step();
        chk("branch captured", {30'd0, valid_out, wb_en_out}, 32'h2);

        drive('{4'b0010, 1, 0, 1, 0, 0, 1, 0, 0, 32'h1, 32'h1, 32'h0, 4'd1});
        step();
        chk("adds clears", {28'd0, status}, 32'h0);
        drive('{4'b0110, 1, 0, 0, 0, 0, 1, 0, 0, 32'hF0, 32'h0F, 32'h0, 4'd1});
        #1;
`ifdef EXE_STATUS_BYPASS_EN
        chk("bypass same cycle", {28'd0, status}, 32'h4);
`else
        chk("no bypass same cycle", {28'd0, status}, 32'h0);
`endif
        step();
        chk("ands z next cycle", {28'd0, status}, 32'h4);

        for (int i = 0; i < 16; i++) begin
            drive(tv[i]);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end
endmodule
